// File: rtl/truth_table_sweeper_pkg.sv
// sweep_pkg: shared types and constants for the truth-table sweeper.
//   sweep_state_e  : sweeper FSM states (IDLE, DRIVE, FINISH)
//   NUM_VEC        : number of input vectors for a 3-input function (8)
//   F_EXP_DEFAULT  : default expected F truth table (8'h3A)
//   tt_merge()     : returns a truth table with one entry replaced
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } sweep_state_e;

    localparam int unsigned NUM_VEC = 8;

    localparam logic [NUM_VEC-1:0] F_EXP_DEFAULT = 8'h3A;

    function automatic logic [NUM_VEC-1:0] tt_merge(
        input logic [NUM_VEC-1:0] tt,
        input logic [2:0]         idx,
        input logic               bit_val
    );
        logic [NUM_VEC-1:0] r;
        r      = tt;
        r[idx] = bit_val;
        return r;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_counter.sv
// sweep_hold_counter: counts 0..HOLD_CYCLES-1 while enabled and wraps.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   clear  : synchronous clear to 0 (used whenever the sweeper is not driving)
//   enable : advance the count
//   last   : high during the final hold cycle of a vector while enabled
module sweep_hold_counter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // With HOLD_CYCLES == 1 the count stays at 0, so every enabled cycle is last.
    assign last = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives x,y,z through all 8 input vectors of a
// downstream 3-input combinational block, holding each for HOLD_CYCLES
// cycles, captures F into an 8-entry truth table and compares it to EXPECTED.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   start     : sweep request, honoured only in IDLE
//   x, y, z   : stimulus vector {x,y,z} (000 outside DRIVE)
//   f_in      : F returned by the downstream block
//   fn_in     : Fn returned by the downstream block
//   busy      : sweep in progress
//   done      : one-cycle completion pulse
//   table_out : captured F truth table, bit i = F for {x,y,z} = i
//   pass      : table matched EXPECTED with no complement error
//   compl_err : sticky, a sample had fn_in == f_in
// Optional feature macro: SWEEP_COMPL_CHK_EN enables the Fn complement check;
// without it fn_in is ignored and compl_err stays 0.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned        HOLD_CYCLES = 4,
    parameter logic [NUM_VEC-1:0] EXPECTED    = F_EXP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               x,
    output logic               y,
    output logic               z,
    input  logic               f_in,
    input  logic               fn_in,
    output logic               busy,
    output logic               done,
    output logic [NUM_VEC-1:0] table_out,
    output logic               pass,
    output logic               compl_err
);

    sweep_state_e       state, state_nxt;
    logic [2:0]         idx;
    logic               sample;
    logic               drive_en;
    logic               start_acc;
    logic [NUM_VEC-1:0] tt_nxt;
    logic               mis;
    logic               compl_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        drive_en    = 1'b0;
        start_acc   = 1'b0;
        {x, y, z}   = 3'b000;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                busy      = 1'b1;
                drive_en  = 1'b1;
                {x, y, z} = idx;
                if (sample && (idx == 3'd7)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    sweep_hold_counter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clear (!drive_en),
        .enable(drive_en),
        .last  (sample)
    );

`ifdef SWEEP_COMPL_CHK_EN
    assign mis = (fn_in == f_in);
`else
    logic unused_fn;
    assign unused_fn = fn_in;
    assign mis       = 1'b0;
`endif

    assign tt_nxt    = tt_merge(table_out, idx, f_in);
    assign compl_nxt = compl_err | mis;

    // The verdict is formed on the vector-7 sample edge from the merged
    // table/flag, so pass is already valid in the FINISH (done) cycle.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            idx       <= '0;
            table_out <= '0;
            pass      <= 1'b0;
            compl_err <= 1'b0;
        end else if (sample) begin
            table_out <= tt_nxt;
            compl_err <= compl_nxt;
            if (idx == 3'd7) begin
                pass <= (tt_nxt == EXPECTED) && !compl_nxt;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

`ifdef SWEEP_COMPL_CHK_EN
    localparam bit COMPL_ON = 1'b1;
`else
    localparam bit COMPL_ON = 1'b0;
`endif

    typedef struct {
        int         mode;   // 0 good, 1 F stuck-0, 2 Fn=F at vector 5, 3 F inverted
        logic [7:0] tab;
        logic       pass;
        logic       compl;
        int         extra;  // cycle of a spurious start during the sweep, 0 = none
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start1;
    logic       x4, y4, z4, f4, fn4, busy4, done4, pass4, ce4;
    logic       x1, y1, z1, f1, fn1, busy1, done1, pass1, ce1;
    logic [7:0] tab4, tab1;
    int         mode;
    int         sel;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[5];

    logic       s_busy, s_done, s_pass, s_ce;
    logic [2:0] s_xyz;
    logic [7:0] s_tab;

    always #5 clk = ~clk;

    truth_table_sweeper #(.HOLD_CYCLES(4), .EXPECTED(8'h3A)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x4), .y(y4), .z(z4),
        .f_in(f4), .fn_in(fn4), .busy(busy4), .done(done4),
        .table_out(tab4), .pass(pass4), .compl_err(ce4)
    );

    truth_table_sweeper #(.HOLD_CYCLES(1), .EXPECTED(8'h3A)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .x(x1), .y(y1), .z(z1),
        .f_in(f1), .fn_in(fn1), .busy(busy1), .done(done1),
        .table_out(tab1), .pass(pass1), .compl_err(ce1)
    );

    // Downstream network F = x'z + xy' with optional injected faults.
    function automatic logic [1:0] net(input logic [2:0] v, input int m);
        logic g, f, fn;
        g  = (!v[2] && v[0]) || (v[2] && !v[1]);
        f  = (m == 1) ? 1'b0 : (m == 3) ? !g : g;
        fn = (m == 2 && v == 3'd5) ? f : !f;
        return {f, fn};
    endfunction

    always_comb {f4, fn4} = net({x4, y4, z4}, mode);
    always_comb {f1, fn1} = net({x1, y1, z1}, mode);

    always_comb begin
        if (sel != 0) begin
            s_busy = busy1; s_done = done1; s_pass = pass1; s_ce = ce1;
            s_xyz  = {x1, y1, z1}; s_tab = tab1;
        end else begin
            s_busy = busy4; s_done = done4; s_pass = pass4; s_ce = ce4;
            s_xyz  = {x4, y4, z4}; s_tab = tab4;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start1 = v;
        else          start4 = v;
    endtask

    // Called #1 after an edge with the selected DUT idle; start is raised
    // immediately so back-to-back calls start one cycle after done.
    task automatic run_sweep(input int dsel, input vec_t v, input string nm);
        int h;
        h    = (dsel != 0) ? 1 : 4;
        sel  = dsel;
        mode = v.mode;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int c = 1; c <= 8 * h + 2; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (c <= 8 * h) begin
                chk($sformatf("%s busy c%0d", nm, c), 32'(s_busy), 32'd1);
                chk($sformatf("%s done c%0d", nm, c), 32'(s_done), 32'd0);
                chk($sformatf("%s xyz c%0d", nm, c), 32'(s_xyz), 32'((c - 1) / h));
            end else begin
                chk($sformatf("%s done c%0d", nm, c), 32'(s_done), (c == 8 * h + 1) ? 32'd1 : 32'd0);
                chk($sformatf("%s busy c%0d", nm, c), 32'(s_busy), 32'd0);
                chk($sformatf("%s xyz c%0d", nm, c), 32'(s_xyz), 32'd0);
                chk($sformatf("%s table c%0d", nm, c), 32'(s_tab), 32'(v.tab));
                chk($sformatf("%s pass c%0d", nm, c), 32'(s_pass), 32'(v.pass));
                chk($sformatf("%s compl c%0d", nm, c), 32'(s_ce), 32'(v.compl));
            end
            if (c == 1) begin
                chk($sformatf("%s table clr", nm), 32'(s_tab), 32'd0);
                chk($sformatf("%s pass clr", nm), 32'(s_pass), 32'd0);
                chk($sformatf("%s compl clr", nm), 32'(s_ce), 32'd0);
            end
            if (v.extra != 0 && c == v.extra)     set_start(1'b1);
            if (v.extra != 0 && c == v.extra + 1) set_start(1'b0);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " busy4"}, 32'(busy4), 32'd0);
        chk({nm, " done4"}, 32'(done4), 32'd0);
        chk({nm, " xyz4"}, 32'({x4, y4, z4}), 32'd0);
        chk({nm, " tab4"}, 32'(tab4), 32'd0);
        chk({nm, " pass4"}, 32'(pass4), 32'd0);
        chk({nm, " ce4"}, 32'(ce4), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h3A, 1'b1, 1'b0, 0};
        vecs[1] = '{0, 8'h3A, 1'b1, 1'b0, 10};
        vecs[2] = '{1, 8'h00, 1'b0, 1'b0, 0};
        vecs[3] = '{2, 8'h3A, !COMPL_ON, COMPL_ON, 0};
        vecs[4] = '{3, 8'hC5, 1'b0, 1'b0, 0};

        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; mode = 0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset tab1", 32'(tab1), 32'd0);

        // Reset together with start: reset wins.
        start4 = 1'b1;
        @(posedge clk); #1;
        chk("rst+start busy", 32'(busy4), 32'd0);
        rst = 1'b0; start4 = 1'b0;
        @(posedge clk); #1;
        chk("rst+start idle", 32'(busy4), 32'd0);

        // Back-to-back sweeps, each started one cycle after the previous done.
        for (int i = 0; i < 5; i++) begin
            run_sweep(0, vecs[i], $sformatf("h4v%0d", i));
        end

        // Reset in the middle of a sweep.
        sel = 0; mode = 0;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int c = 2; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        chk("midrst busy before", 32'(busy4), 32'd1);
        chk("midrst partial table", 32'(tab4), 32'h02);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_vals("midrst");
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst no done c%0d", c), 32'(done4 | busy4), 32'd0);
        end
        run_sweep(0, vecs[0], "after_rst");

        // Single-cycle hold.
        run_sweep(1, vecs[0], "h1good");
        run_sweep(1, vecs[2], "h1stuck");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential stimulus-and-capture stage placed directly upstream of the team's 3-input gate-level function blocks.
- It drives x, y, z through all eight input combinations, holding each one for a programmable number of cycles.
- It samples the block's F and Fn outputs once per vector and assembles the captured 8-entry truth table.
- It compares the table against an expected value and reports pass/fail, so gate-level networks can be checked in hardware without a hand-written testbench.

## Interface
- HOLD_CYCLES, 4, cycles each input vector is held (legal range 1..255).
- EXPECTED, 8'h3A, expected F truth table; bit i = F for {x,y,z} = i.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- start  input  1  sweep request; sampled only in IDLE.
- x  output  1  stimulus MSB to downstream function.
- y  output  1  stimulus middle bit.
- z  output  1  stimulus LSB.
- f_in  input  1  F returned from downstream function.
- fn_in  input  1  Fn returned from downstream function.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- table_out  output  8  captured F truth table.
- pass  output  1  table_out == EXPECTED and no complement error; valid from done onward.
- compl_err  output  1  sticky flag: a sample had fn_in == f_in.

## Operation
- FSM states and transitions:
  - IDLE -> DRIVE on start.
  - DRIVE -> DRIVE while vectors remain.
  - DRIVE -> FINISH after vector 7 is sampled.
  - FINISH -> IDLE unconditionally.
- Vector index idx is 3 bits; {x,y,z} = idx in DRIVE and 3'b000 in IDLE and FINISH.
- Hold counter counts 0..HOLD_CYCLES-1 per vector; counter width is max(1, $clog2(HOLD_CYCLES)).
- Sampling: at hold_cnt == HOLD_CYCLES-1, table_out[idx] <= f_in.
- Vector advance: in the same sampling cycle, idx increments and hold_cnt returns to 0.
- When idx == 7 is sampled, there is no wrap back to 0; the FSM moves to FINISH.
- On start acceptance: table_out, pass and compl_err clear to 0 and idx = 0.
- In FINISH:
  - done = 1 for one cycle.
  - pass <= (final table == EXPECTED) && !compl_err_final, where both include the vector-7 sample.
- pass, table_out and compl_err hold their values until the next accepted start or reset.
- start while busy or in FINISH is ignored, not queued.
- HOLD_CYCLES == 1: one vector per cycle; sample on every DRIVE cycle.

## Timing
- Reset values: x=y=z=0, busy=0, done=0, table_out=0, pass=0, compl_err=0; state IDLE.
- start high in IDLE at edge t gives:
  - busy=1 and {x,y,z}=000 from t+1.
  - Vector k is driven from t+1+k*HOLD_CYCLES.
  - Vector k is sampled at edge t+(k+1)*HOLD_CYCLES.
- done pulses in cycle t+8*HOLD_CYCLES+1; busy falls in that same cycle.
- Earliest next start is accepted one cycle after done.
- The downstream function is combinational, so f_in is treated as valid HOLD_CYCLES-1 cycles after each vector change.
- Reset mid-sweep aborts immediately; all outputs return to reset values on the next edge and no done is produced.
- Reset and start asserted together: reset wins.

## Configuration
- SWEEP_COMPL_CHK_EN defined:
  - At each sample point, compl_err sets if fn_in != ~f_in.
  - pass requires compl_err == 0.
- SWEEP_COMPL_CHK_EN undefined:
  - fn_in is ignored and compl_err is tied 0.
  - pass depends only on the table compare.

## Structure
- Package sweep_pkg holds:
  - State enum {IDLE, DRIVE, FINISH}.
  - NUM_VEC = 8.
  - Default expected-table constant F_EXP_DEFAULT = 8'h3A.
- One natural sub-module, sweep_hold_counter:
  - Parameterised hold counter with clear/enable.
  - Outputs a last-cycle strobe used for sampling and index advance.

## Test plan
- Correct network: HOLD_CYCLES=4, downstream model F = x'z + xy', Fn = ~F, start pulse -> done at cycle 33 after start, table_out=8'h3A, pass=1, compl_err=0.
- Stuck-at fault: F forced 0 -> table_out=8'h00, pass=0.
- Complement fault with SWEEP_COMPL_CHK_EN: Fn = F at vector 5 only -> compl_err=1, pass=0, table_out=8'h3A; without the macro -> compl_err=0, pass=1.
- Start ignored: second start at cycle 10 of a sweep -> no restart, a single done pulse, table unchanged; start one cycle after done -> new sweep, pass cleared during busy.
- Reset mid-sweep: rst at cycle 15 -> next edge gives all outputs 0 and IDLE, no done; a fresh start completes normally with pass=1.
- HOLD_CYCLES=1: vectors change every cycle, done at cycle 9 after start, table_out=8'h3A.
